// File: rtl/push_rp_sequencer.sv
// push_rp_sequencer: PUSH rr sequencer that writes a register pair to SP-1 (high byte) then SP-2 (low byte)
module push_rp_sequencer #(
  parameter int WAIT_STEP = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Tick,
  input  logic       i_Start,
  input  logic [1:0] i_P,
  input  logic       i_Wait,
  input  logic [7:0] i_Reg_Data,
  output logic [7:0] o_Read8,
  output logic       o_Addr_SP,
  output logic       o_Address_Out,
  output logic       o_Dec_SP,
  output logic       o_Bus_Out,
  output logic [7:0] o_Bus_Data,
  output logic       o_Mem_Write,
  output logic       o_IR_Fetch,
  output logic       o_Busy,
  output logic       o_Done
);
  typedef enum logic [1:0] {IDLE, DEC, WR_HI, WR_LO} state_t;
  state_t state, state_nx;
  logic [1:0] step, step_nx, pair, pair_nx;
  logic wr, last, hold;
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state <= IDLE;
      step  <= 2'd0;
      pair  <= 2'd0;
    end else if (i_Tick) begin
      state <= state_nx;
      step  <= step_nx;
      pair  <= pair_nx;
    end
  always_comb begin
    wr            = (state == WR_HI) || (state == WR_LO);
    last          = step == 2'd3;
    hold          = wr && (step == 2'(WAIT_STEP)) && i_Wait;
    state_nx      = state == IDLE ? (i_Start ? DEC : IDLE) :
                    !last ? state :
                    state == DEC ? WR_HI :
                    state == WR_HI ? WR_LO : IDLE;
    step_nx       = state == IDLE ? 2'd0 : hold ? step : step + 2'd1;
    pair_nx       = (state == IDLE) && i_Start ? i_P : pair;
    o_Read8       = state == WR_HI ? 8'h80 >> {pair, 1'b0} :
                    state == WR_LO ? 8'h40 >> {pair, 1'b0} : 8'h00;
    o_Addr_SP     = wr;
    o_Address_Out = wr;
    o_Bus_Out     = wr;
    o_Bus_Data    = !wr ? 8'h00 :
                    (state == WR_LO) && (pair == 2'd3) ? {i_Reg_Data[7:4], 4'h0} : i_Reg_Data;
    o_Dec_SP      = ((state == DEC) && (step == 2'd1)) || ((state == WR_HI) && last);
    o_Mem_Write   = wr && (step == 2'(WAIT_STEP));
    o_Done        = (state == WR_LO) && last;
    o_IR_Fetch    = (state == WR_LO) && last;
    o_Busy        = state != IDLE;
  end
endmodule

// File: tb/tb_push_rp_sequencer.sv
// tb_push_rp_sequencer: table-driven PUSH sequences checked against a write scoreboard and SP/memory model
module tb_push_rp_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0, wt = 1'b0;
  logic [1:0] p = 2'd0;
  logic [7:0] reg_data, read8, bus_data;
  logic addr_sp, addr_out, dec_sp, bus_out, mem_wr, ir_fetch, busy, done;
  logic [7:0] reg_file [8];
  logic [7:0] mem [65536];
  logic [15:0] sp;
  logic [23:0] outs;
  int checks = 0, errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  rd;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [1:0] p;
    logic [7:0] hi, lo;
    int         waits, div;
    logic       ign;
    logic [7:0] exp_hi, exp_lo, rd_hi, rd_lo;
    int         done_t;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  push_rp_sequencer #(.WAIT_STEP(2)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Tick(tick), .i_Start(start), .i_P(p),
    .i_Wait(wt), .i_Reg_Data(reg_data), .o_Read8(read8), .o_Addr_SP(addr_sp),
    .o_Address_Out(addr_out), .o_Dec_SP(dec_sp), .o_Bus_Out(bus_out),
    .o_Bus_Data(bus_data), .o_Mem_Write(mem_wr), .o_IR_Fetch(ir_fetch),
    .o_Busy(busy), .o_Done(done)
  );

  always_comb begin
    reg_data = 8'h00;
    for (int i = 0; i < 8; i++) if (read8[i]) reg_data = reg_data | reg_file[i];
  end

  assign outs = {read8, addr_sp, addr_out, dec_sp, bus_out, bus_data, mem_wr, ir_fetch, busy, done};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_push(input vec_t v);
    int t = 0, clk_n = 0, waits = v.waits, mw = 0, done_t = -1;
    int dec_q[$], wr_q[$];
    logic [23:0] prev = '0;
    logic prev_tick = 1'b1, prev_busy = 1'b0;
    wr_t e;
    for (int i = 0; i < 8; i++) reg_file[i] = 8'(8'h11 * (i + 1));
    reg_file[7 - 2 * int'(v.p)] = v.hi;
    reg_file[6 - 2 * int'(v.p)] = v.lo;
    sp = 16'hFFFE;
    for (int a = 16'hFFFC; a <= 16'hFFFF; a++) mem[a] = 8'h00;
    sb.push_back('{16'hFFFD, v.exp_hi, v.rd_hi});
    sb.push_back('{16'hFFFC, v.exp_lo, v.rd_lo});
    p = v.p;
    while (done_t < 0 && clk_n < 400) begin
      @(negedge clk);
      tick = (clk_n % v.div) == 0;
      start = clk_n == 0 ? 1'b1 : (v.ign && prev_busy);
      wt = 1'b0;
      #1;
      if (!prev_tick) chk("hold_no_tick", outs, prev);
      if (tick) begin
        if (mem_wr && read8 == v.rd_hi && waits > 0) begin
          wt = 1'b1;
          waits--;
        end
        if (mem_wr) mw++;
        if (mem_wr && !wt) begin
          wr_q.push_back(t);
          chk("wr_bus_en", {addr_sp, addr_out, bus_out}, 3'b111);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_addr", sp, e.addr);
            chk("wr_data", bus_data, e.data);
            chk("wr_read8", read8, e.rd);
          end
          mem[sp] = bus_data;
        end
        if (dec_sp) begin
          dec_q.push_back(t);
          sp--;
        end
        if (done) begin
          done_t = t;
          chk("ir_fetch", ir_fetch, 1);
          chk("done_clk", clk_n, v.done_t * v.div);
        end
        t++;
      end
      prev = outs;
      prev_tick = tick;
      prev_busy = busy;
      clk_n++;
    end
    chk("done_tick", done_t, v.done_t);
    chk("dec_count", dec_q.size(), 2);
    if (dec_q.size() == 2) begin
      chk("dec_tick0", dec_q[0], 2);
      chk("dec_tick1", dec_q[1], 8 + v.waits);
    end
    chk("n_writes", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("wr_tick_hi", wr_q[0], 7 + v.waits);
      chk("wr_tick_lo", wr_q[1], 11 + v.waits);
    end
    chk("mem_wr_ticks", mw, 2 + v.waits);
    chk("sp_final", sp, 16'hFFFC);
    chk("mem_hi", mem[16'hFFFD], v.exp_hi);
    chk("mem_lo", mem[16'hFFFC], v.exp_lo);
    chk("sb_left", sb.size(), 0);
    sb.delete();
    repeat (4) begin
      @(negedge clk);
      tick = 1'b1;
      start = 1'b0;
      wt = 1'b0;
      #1;
      chk("idle_after", {busy, mem_wr}, 2'b00);
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, 8'h12, 8'h34, 0, 1, 1'b0, 8'h12, 8'h34, 8'h80, 8'h40, 12};
    vecs[1] = '{2'd3, 8'hC3, 8'hBF, 0, 1, 1'b0, 8'hC3, 8'hB0, 8'h02, 8'h01, 12};
    vecs[2] = '{2'd1, 8'h5A, 8'hA5, 3, 1, 1'b0, 8'h5A, 8'hA5, 8'h20, 8'h10, 15};
    vecs[3] = '{2'd2, 8'h9F, 8'h0F, 0, 4, 1'b1, 8'h9F, 8'h0F, 8'h08, 8'h04, 12};
    for (int i = 0; i < 8; i++) reg_file[i] = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      tick = 1'($urandom);
      start = 1'($urandom);
      wt = 1'($urandom);
      p = 2'($urandom);
      #1;
      chk("reset_outs", outs, 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tick = 1'b1;
      wt = 1'($urandom);
      #1;
      chk("post_reset_outs", outs, 24'h0);
    end
    for (int k = 0; k < 4; k++) run_push(vecs[k]);
    p = 2'd0;
    @(negedge clk);
    tick = 1'b1;
    start = 1'b1;
    wt = 1'b0;
    #1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    chk("pre_reset_whi1", {addr_sp, mem_wr, busy}, 3'b101);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs, 24'h0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("in_reset", outs, 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("after_reset_idle", outs, 24'h0);
    end
    run_push('{2'd2, 8'h77, 8'h66, 0, 1, 1'b0, 8'h77, 8'h66, 8'h08, 8'h04, 12});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/push_rp_sequencer.md
Name: push_rp_sequencer

Overview:
- Self-timed control sequencer for PUSH rr: stores a register pair (BC, DE, HL, AF) to the stack at SP-1 (high byte) and SP-2 (low byte).
- It is the write-direction counterpart of the 16-bit immediate load path, which moves memory into a register pair.
- Sits in the control unit beside the microcode blocks and is started by the decoder after the opcode fetch.
- Drives register-file selects, the SP decrementer, the address mux, the outbound data bus and the memory write strobe.

Parameters:
- WAIT_STEP, 2, T-step (0-3) of a write M-cycle at which o_Mem_Write is asserted and i_Wait is sampled.

Ports:
- i_Clk  in  1  system clock
- i_Reset_n  in  1  asynchronous active-low reset
- i_Tick  in  1  T-state enable; state advances only on i_Clk edges with i_Tick=1
- i_Start  in  1  decoder launch pulse; honoured only in IDLE with i_Tick=1
- i_P  in  2  pair select, sampled at start: 0=BC, 1=DE, 2=HL, 3=AF
- i_Wait  in  1  memory not ready; stalls the write T-step
- i_Reg_Data  in  8  byte returned by the register file for o_Read8
- o_Read8  out  8  one-hot register read select: bit7 B, 6 C, 5 D, 4 E, 3 H, 2 L, 1 A, 0 F
- o_Addr_SP  out  1  selects SP onto the address bus
- o_Address_Out  out  1  address bus output enable
- o_Dec_SP  out  1  one-tick SP decrement strobe
- o_Bus_Out  out  1  data bus output enable
- o_Bus_Data  out  8  outbound data byte
- o_Mem_Write  out  1  memory write strobe
- o_IR_Fetch  out  1  overlap fetch of the next opcode
- o_Busy  out  1  sequence in progress
- o_Done  out  1  one-tick completion pulse

Behaviour:
- Registered state machine (IDLE, DEC, WR_HI, WR_LO) plus a 2-bit T-step counter. Both advance only when i_Tick=1.
- Reset, asynchronous: state=IDLE, step=0, latched pair=0. Every output is 0, including o_Bus_Data=8'h00.
- IDLE: all outputs 0. On i_Start & i_Tick, latch i_P, go to DEC with step=0. i_Start in any other state is ignored.
- DEC (internal M-cycle): o_Dec_SP=1 during step 1 only. After step 3 go to WR_HI.
- WR_HI, WR_LO, all steps: o_Addr_SP=1, o_Address_Out=1, o_Bus_Out=1, o_Read8 selects the byte.
  - WR_HI byte: B, D, H or A.
  - WR_LO byte: C, E, L or F.
- Bus data: o_Bus_Data = i_Reg_Data (combinational pass-through). When the selected register is F, bits [3:0] are forced to 0.
- At step WAIT_STEP: o_Mem_Write=1. If i_Wait=1 on a tick, the step counter holds, and o_Mem_Write and all bus outputs stay asserted until a tick with i_Wait=0.
- WR_HI step 3: o_Dec_SP=1. Then go to WR_LO.
- WR_LO step 3: o_IR_Fetch=1 and o_Done=1 for exactly that tick (combinational on state and step). Next state is IDLE.
- o_Busy = (state != IDLE).
- Full sequence with no waits: 12 ticks from the start tick to the Done tick; SP is decremented exactly twice.
- i_Tick=0: all registered state holds and outputs stay stable. Combinational strobes still reflect current state and step; consumers qualify them with i_Tick.
- i_Wait outside step WAIT_STEP of a write state is ignored.
- i_Start on the tick o_Done is high is not accepted. The next start is honoured from IDLE on the following tick.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. No write strobe after reset deassertion until a new start.
- RTL uses only i_Clk edges and the asynchronous i_Reset_n. No latches, and no combinational path from i_Wait to the state registers except through the step-hold enable.

Test Plan:
- Reset: i_Reset_n=0 for 3 clocks with random inputs -> all outputs 0, o_Busy=0. Release -> still 0 until i_Start.
- PUSH BC, i_Tick=1 every clock, i_Wait=0, register model B=8'h12, C=8'h34:
  - o_Dec_SP pulses at ticks 2 and 8.
  - o_Mem_Write at tick 7 with o_Read8=8'h80, o_Bus_Data=8'h12.
  - o_Mem_Write at tick 11 with o_Read8=8'h40, o_Bus_Data=8'h34.
  - o_Done and o_IR_Fetch at tick 12.
  - With SP model starting at 16'hFFFE: memory FFFD=8'h12, FFFC=8'h34, SP ends at 16'hFFFC.
- PUSH AF, A=8'hC3, F=8'hBF -> high byte 8'hC3 written, low byte 8'hB0 written (low nibble masked).
- i_Wait=1 for 3 ticks at WR_HI step 2 -> o_Mem_Write held for 4 ticks, total sequence 15 ticks, byte order and SP result unchanged.
- i_Tick=1 only every 4th clock -> same 12-tick sequence (48 clocks), no state change on non-tick clocks. i_Start pulses while o_Busy=1 are ignored, with no second sequence.
- Reset asserted at WR_HI step 1 -> outputs 0 at once, no o_Mem_Write. A new PUSH HL then completes normally with H first, then L.
